ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage MIPS pipeline. It takes the decoded operands and control bits held in ID/EX and the 4-bit `ALUsignal` produced by ALU control. It performs operand forwarding and the ALU operation, then registers the result and the pass-through control into the EX/MEM pipeline register. An optional iterative multiplier can be compiled in; it holds the stage for 32 cycles and requests an upstream stall while it runs.

## Interface

Parameters:
- `WIDTH`, 32, datapath width. Only 32 is supported.

Ports (name, direction, width, meaning):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: ID/EX holds a real instruction, not a bubble.
- `ALUsignal` in 4: operation code from ALU control.
- `rs_data`, `rt_data` in 32 each: register-file read values.
- `imm` in 32: sign-extended immediate.
- `ALUSrc` in 1: 1 selects `imm` as operand B.
- `fwd_a`, `fwd_b` in 2 each: forwarding selects. 00 = register file, 01 = `wb_data`, 10 = `exmem_result`, 11 = same as 00.
- `wb_data` in 32: MEM/WB writeback value.
- `rd_in` in 5: destination register.
- `RegWrite_in`, `MemRead_in`, `MemWrite_in`, `MemtoReg_in` in 1 each: control bits passed through.
- `mem_stall` in 1: downstream stall; holds EX/MEM.
- `flush` in 1: kills the instruction currently in EX.
- `ex_busy` out 1: multiplier stall request to the hazard unit.
- `exmem_valid` out 1: EX/MEM holds a valid instruction.
- `exmem_result` out 32: registered ALU result.
- `exmem_store_data` out 32: registered forwarded operand B, taken before the `ALUSrc` mux.
- `exmem_zero` out 1: registered (result == 0).
- `exmem_rd` out 5: registered destination register.
- `exmem_RegWrite`, `exmem_MemRead`, `exmem_MemWrite`, `exmem_MemtoReg` out 1 each: registered control bits.

## Operation

- Operand A = forwarded rs. Operand B = `ALUSrc` ? `imm` : forwarded rt.
- ALU codes:
  - 0000: add
  - 0001: sub
  - 0010: and
  - 0011: or
  - 0101: slt (signed compare, result 0 or 1)
  - 0110: mul (only with `EX_MULT_EN`; low 32 bits of the unsigned product)
  - all other codes: result 0
- Add and sub wrap modulo 2^32. There is no overflow trap and no overflow flag.
- EX/MEM register update priority, highest first:
  1. `flush`: load a bubble (`exmem_valid` = 0, all four control bits 0, data fields don't-care).
  2. `mem_stall`: hold all fields.
  3. Multiplier running: load a bubble.
  4. Otherwise: load the ALU result and the pass-through fields, with `exmem_valid` = `in_valid`.
- Bubble rule: when `in_valid` = 0, the registered control bits are forced to 0.
- Multiplier FSM, states IDLE and MUL, 5-bit counter `cnt`:
  - IDLE to MUL: `in_valid` & code 0110 & !`flush` & !`mem_stall`. Operands are latched and `cnt` is set to 0.
  - MUL: one shift-add step per cycle; `cnt` increments.
  - At `cnt` = 31 with !`mem_stall`: the final product is written to EX/MEM (normal priority 4) and the FSM returns to IDLE.
  - At `cnt` = 31 with `mem_stall`: stay in MUL at 31 with no further steps; the product is held.
  - `flush` in MUL: return to IDLE and discard the product.
- `ex_busy` (combinational) = (IDLE & `in_valid` & code 0110) | (MUL & `cnt` != 31).
- The hazard unit freezes PC, IF/ID and ID/EX on `ex_busy` | `mem_stall`. That stall logic is outside this block.

## Timing

- Reset values:
  - All `exmem_*` outputs = 0.
  - `ex_busy` = 0 unless its combinational term is true.
  - FSM = IDLE, `cnt` = 0.
- Non-multiply latency: an instruction present in EX in cycle N is visible on `exmem_*` after the rising edge ending cycle N.
- Multiply latency: accepted in cycle N; result visible after the edge ending cycle N+32. `ex_busy` is high during cycles N..N+31 and low in cycle N+32.
- Simultaneous `flush` and `mem_stall`: `flush` wins.
- `rst_n` low mid-multiply: the FSM returns to IDLE immediately and the partial product is lost.
- Forwarding and ALU paths are combinational within one cycle. `exmem_result` feeds back through select 10.

## Configuration

- `EX_MULT_EN` defined: multiplier FSM, product and counter registers are present; code 0110 performs multiply.
- `EX_MULT_EN` undefined:
  - no multiplier logic;
  - `ex_busy` tied to 0;
  - code 0110 yields result 0 with single-cycle latency, like any other undefined code.

## Test plan

- Reset, then release with no input: all `exmem_*` = 0.
- Add and subtract: code 0000 with rs = 0x7FFFFFFF, rt = 1 gives `exmem_result` = 0x80000000 one cycle later. Code 0001 with 5 - 5 gives result 0 and `exmem_zero` = 1.
- Signed slt: rs = 0xFFFFFFFF, rt = 1 gives result 1. With ALUSrc = 1 and imm = 0xFFFFFFFE against rs = 0, the result is 0.
- Forwarding: with `exmem_result` = 0x10, `fwd_a` = 10, rt = 3 and code 0000, the result is 0x13. With `fwd_b` = 01, `wb_data` = 7 and sw controls, `exmem_store_data` = 7.
- Stall and flush: with `mem_stall` held for 3 cycles, `exmem_*` stay unchanged. `flush` together with `mem_stall` gives `exmem_valid` = 0 and all control bits 0 on the next edge.
- With `EX_MULT_EN`:
  - 0x00010003 × 0x00000005 gives 0x0005000F after 33 cycles, with `ex_busy` high for exactly 32 cycles.
  - `flush` at `cnt` = 10 returns the FSM to IDLE, drops `ex_busy` and gives `exmem_valid` = 0.
  - Without the macro, the same multiply stimulus gives result 0 with `ex_busy` never asserted.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage MIPS pipeline.
// Forwards operands, runs the ALU and registers the result plus pass-through
// control into EX/MEM. Define EX_MULT_EN to build in the 32-cycle iterative
// multiplier (ALU code 0110); without it code 0110 yields 0 like any other
// undefined code and ex_busy is tied low.
module ex_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [3:0]       ALUsignal,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic [WIDTH-1:0] imm,
   input  logic             ALUSrc,
   input  logic [1:0]       fwd_a,
   input  logic [1:0]       fwd_b,
   input  logic [WIDTH-1:0] wb_data,
   input  logic [4:0]       rd_in,
   input  logic             RegWrite_in,
   input  logic             MemRead_in,
   input  logic             MemWrite_in,
   input  logic             MemtoReg_in,
   input  logic             mem_stall,
   input  logic             flush,
   output logic             ex_busy,
   output logic             exmem_valid,
   output logic [WIDTH-1:0] exmem_result,
   output logic [WIDTH-1:0] exmem_store_data,
   output logic             exmem_zero,
   output logic [4:0]       exmem_rd,
   output logic             exmem_RegWrite,
   output logic             exmem_MemRead,
   output logic             exmem_MemWrite,
   output logic             exmem_MemtoReg
);

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_SLT = 4'b0101;

   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] result;
      logic [WIDTH-1:0] store_data;
      logic             zero;
      logic [4:0]       rd;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic             mem_to_reg;
   } exmem_t;

   exmem_t           exmem_d, exmem_q;
   logic [WIDTH-1:0] op_a, rt_fwd, op_b;
   logic [WIDTH-1:0] alu_result, ex_result;
   logic             mul_done;      // multiplier's final cycle: product goes to EX/MEM
   logic [WIDTH-1:0] mul_product;

   // 00/11 register file, 01 MEM/WB value, 10 EX/MEM result
   function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0]       sel,
                                                input logic [WIDTH-1:0] reg_val,
                                                input logic [WIDTH-1:0] wb_val,
                                                input logic [WIDTH-1:0] ex_val);
      case (sel)
         2'b01:   return wb_val;
         2'b10:   return ex_val;
         default: return reg_val;
      endcase
   endfunction

   assign op_a   = fwd_mux(fwd_a, rs_data, wb_data, exmem_q.result);
   assign rt_fwd = fwd_mux(fwd_b, rt_data, wb_data, exmem_q.result);
   assign op_b   = ALUSrc ? imm : rt_fwd;

   // Single-cycle ALU; add/sub wrap with no overflow indication
   always_comb begin
      // NOTE: assign a default before the case so no path leaves alu_result unassigned (that would infer a latch).
      alu_result = '0;
      case (ALUsignal)
         ALU_ADD: alu_result = op_a + op_b;
         ALU_SUB: alu_result = op_a - op_b;
         ALU_AND: alu_result = op_a & op_b;
         ALU_OR:  alu_result = op_a | op_b;
         ALU_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         default: alu_result = '0;
      endcase
   end

`ifdef EX_MULT_EN
   localparam logic [3:0] ALU_MUL = 4'b0110;

   typedef enum logic {IDLE, MUL} mul_state_t;

   mul_state_t       state_d, state_q;
   logic [4:0]       cnt_d, cnt_q;
   logic [WIDTH-1:0] mcand_d, mcand_q;    // multiplicand, shifted left each step
   logic [WIDTH-1:0] mplier_d, mplier_q;  // multiplier, shifted right each step
   logic [WIDTH-1:0] prod_d, prod_q;      // running partial product
   logic             mul_req;
   logic [WIDTH-1:0] step_sum;

   assign mul_req     = (state_q == IDLE) && in_valid && (ALUsignal == ALU_MUL);
   assign mul_done    = (state_q == MUL) && (cnt_q == 5'd31);
   assign step_sum    = prod_q + (mplier_q[0] ? mcand_q : '0);
   // The 32nd partial product is added combinationally in the final cycle
   assign mul_product = step_sum;
   assign ex_busy     = mul_req || ((state_q == MUL) && (cnt_q != 5'd31));

   // Multiplier next state: accept, shift-add step, finish or abort on flush
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      case (state_q)
         IDLE: begin
            if (mul_req && !flush && !mem_stall) begin
               state_d  = MUL;
               cnt_d    = '0;
               mcand_d  = op_a;
               mplier_d = op_b;
               prod_d   = '0;
            end
         end
         MUL: begin
            if (flush) begin
               state_d = IDLE;
            end else if (cnt_q == 5'd31) begin
               // Product stays parked here while the downstream stall lasts
               if (!mem_stall) state_d = IDLE;
            end else begin
               prod_d   = step_sum;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Multiplier state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
      end
   end
`else
   assign ex_busy     = 1'b0;
   assign mul_done    = 1'b0;
   assign mul_product = '0;
`endif

   assign ex_result = mul_done ? mul_product : alu_result;

   // EX/MEM next value: flush > mem_stall > multiplier occupancy > normal load.
   // The multiply's own accept cycle counts as occupancy so it is written only once.
   always_comb begin
      exmem_d = exmem_q;
      if (flush) begin
         exmem_d.valid      = 1'b0;
         exmem_d.reg_write  = 1'b0;
         exmem_d.mem_read   = 1'b0;
         exmem_d.mem_write  = 1'b0;
         exmem_d.mem_to_reg = 1'b0;
      end else if (mem_stall) begin
         exmem_d = exmem_q;
      end else if (ex_busy) begin
         exmem_d.valid      = 1'b0;
         exmem_d.reg_write  = 1'b0;
         exmem_d.mem_read   = 1'b0;
         exmem_d.mem_write  = 1'b0;
         exmem_d.mem_to_reg = 1'b0;
      end else begin
         exmem_d.valid      = in_valid;
         exmem_d.result     = ex_result;
         exmem_d.store_data = rt_fwd;
         exmem_d.zero       = (ex_result == '0);
         exmem_d.rd         = rd_in;
         exmem_d.reg_write  = RegWrite_in & in_valid;
         exmem_d.mem_read   = MemRead_in  & in_valid;
         exmem_d.mem_write  = MemWrite_in & in_valid;
         exmem_d.mem_to_reg = MemtoReg_in & in_valid;
      end
   end

   // EX/MEM pipeline register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) exmem_q <= '0;
      else        exmem_q <= exmem_d;
   end

   assign exmem_valid      = exmem_q.valid;
   assign exmem_result     = exmem_q.result;
   assign exmem_store_data = exmem_q.store_data;
   assign exmem_zero       = exmem_q.zero;
   assign exmem_rd         = exmem_q.rd;
   assign exmem_RegWrite   = exmem_q.reg_write;
   assign exmem_MemRead    = exmem_q.mem_read;
   assign exmem_MemWrite   = exmem_q.mem_write;
   assign exmem_MemtoReg   = exmem_q.mem_to_reg;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed test of ex_stage against a cycle-level reference model.
// Follows EX_MULT_EN so the same bench covers both builds.
module tb_ex_stage;

`ifdef EX_MULT_EN
   localparam bit MULT_EN = 1'b1;
`else
   localparam bit MULT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  alu_sig = '0;
   logic [31:0] rs_data = '0, rt_data = '0, imm = '0, wb_data = '0;
   logic        alu_src = 1'b0;
   logic [1:0]  fwd_a = '0, fwd_b = '0;
   logic [4:0]  rd_in = '0;
   logic        reg_write_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0, mem_to_reg_in = 1'b0;
   logic        mem_stall = 1'b0, flush = 1'b0;

   logic        ex_busy, exmem_valid, exmem_zero;
   logic [31:0] exmem_result, exmem_store_data;
   logic [4:0]  exmem_rd;
   logic        exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg;

   int n_vec  = 0;
   int n_miss = 0;
   bit done   = 1'b0;

   ex_stage #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ALUsignal(alu_sig),
      .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .ALUSrc(alu_src),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_data(wb_data), .rd_in(rd_in),
      .RegWrite_in(reg_write_in), .MemRead_in(mem_read_in),
      .MemWrite_in(mem_write_in), .MemtoReg_in(mem_to_reg_in),
      .mem_stall(mem_stall), .flush(flush), .ex_busy(ex_busy),
      .exmem_valid(exmem_valid), .exmem_result(exmem_result),
      .exmem_store_data(exmem_store_data), .exmem_zero(exmem_zero),
      .exmem_rd(exmem_rd), .exmem_RegWrite(exmem_reg_write),
      .exmem_MemRead(exmem_mem_read), .exmem_MemWrite(exmem_mem_write),
      .exmem_MemtoReg(exmem_mem_to_reg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        valid;
      logic [31:0] result;
      logic [31:0] store;
      logic        zero;
      logic [4:0]  rd;
      logic        rw, mr, mw, m2r;
   } exp_t;

   exp_t        exp_q = '0;
   bit          m_on = 1'b0;        // a multiply has been accepted and is in flight
   int          m_elapsed = 0;      // cycles spent in flight, saturating at 31
   logic [31:0] m_prod = '0;
   logic        exp_busy;

   assign exp_busy = MULT_EN && ((!m_on && in_valid && alu_sig == 4'b0110) ||
                                 (m_on && m_elapsed < 31));

   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                        input logic [31:0] wb, input logic [31:0] ex);
      if (sel == 2'b01) return wb;
      if (sel == 2'b10) return ex;
      return r;
   endfunction

   function automatic logic [31:0] alu_model(input logic [3:0] code, input logic [31:0] a,
                                             input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      case (code)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd5:    return (sa < sb) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin : model
      logic [31:0] a, st, b, res;
      exp_t        nxt;
      bit          busy_now;
      busy_now = exp_busy;
      nxt = exp_q;
      a   = pick(fwd_a, rs_data, wb_data, exp_q.result);
      st  = pick(fwd_b, rt_data, wb_data, exp_q.result);
      b   = alu_src ? imm : st;
      res = (m_on && m_elapsed == 31) ? m_prod : alu_model(alu_sig, a, b);
      if (!rst_n) begin
         exp_q <= '0;
         m_on <= 1'b0;
         m_elapsed <= 0;
      end else if (flush) begin
         nxt.valid = 0; nxt.rw = 0; nxt.mr = 0; nxt.mw = 0; nxt.m2r = 0;
         exp_q <= nxt;
         m_on  <= 1'b0;
      end else if (mem_stall) begin
         if (m_on && m_elapsed < 31) m_elapsed <= m_elapsed + 1;
      end else if (busy_now) begin
         nxt.valid = 0; nxt.rw = 0; nxt.mr = 0; nxt.mw = 0; nxt.m2r = 0;
         exp_q <= nxt;
         if (m_on) m_elapsed <= m_elapsed + 1;
         else begin
            m_on      <= 1'b1;
            m_elapsed <= 0;
            m_prod    <= a * b;
         end
      end else begin
         nxt.valid  = in_valid;
         nxt.result = res;
         nxt.store  = st;
         nxt.zero   = (res == 32'd0);
         nxt.rd     = rd_in;
         nxt.rw     = reg_write_in  & in_valid;
         nxt.mr     = mem_read_in   & in_valid;
         nxt.mw     = mem_write_in  & in_valid;
         nxt.m2r    = mem_to_reg_in & in_valid;
         exp_q <= nxt;
         m_on  <= 1'b0;
      end
   end

   // Compare every cycle on the falling edge, away from input changes and the active edge
   always @(negedge clk) begin
      if (rst_n && !done) begin
         check("busy",     {31'd0, ex_busy},          {31'd0, exp_busy});
         check("valid",    {31'd0, exmem_valid},      {31'd0, exp_q.valid});
         check("regwrite", {31'd0, exmem_reg_write},  {31'd0, exp_q.rw});
         check("memread",  {31'd0, exmem_mem_read},   {31'd0, exp_q.mr});
         check("memwrite", {31'd0, exmem_mem_write},  {31'd0, exp_q.mw});
         check("memtoreg", {31'd0, exmem_mem_to_reg}, {31'd0, exp_q.m2r});
         if (exp_q.valid) begin
            check("result", exmem_result,          exp_q.result);
            check("store",  exmem_store_data,      exp_q.store);
            check("zero",   {31'd0, exmem_zero},   {31'd0, exp_q.zero});
            check("rd",     {27'd0, exmem_rd},     {27'd0, exp_q.rd});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      in_valid = 0; alu_sig = '0; rs_data = '0; rt_data = '0; imm = '0; wb_data = '0;
      alu_src = 0; fwd_a = '0; fwd_b = '0; rd_in = '0;
      reg_write_in = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0;
      mem_stall = 0; flush = 0;
   endtask

   task automatic alu_op(input logic [3:0] code, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] rd);
      idle();
      in_valid = 1; alu_sig = code; rs_data = rs; rt_data = rt; rd_in = rd; reg_write_in = 1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int busy_cycles;
      idle();
      rst_n = 0;
      step(); step();
      rst_n = 1;
      step();
      check("reset valid",  {31'd0, exmem_valid}, 32'd0);
      check("reset result", exmem_result, 32'd0);
      check("reset ctrl",   {28'd0, exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg}, 32'd0);
      check("reset busy",   {31'd0, ex_busy}, 32'd0);

      alu_op(4'b0000, 32'h7FFF_FFFF, 32'd1, 5'd3); step();
      check("add wrap", exmem_result, 32'h8000_0000);
      check("add valid", {31'd0, exmem_valid}, 32'd1);

      alu_op(4'b0001, 32'd5, 32'd5, 5'd4); step();
      check("sub result", exmem_result, 32'd0);
      check("sub zero",   {31'd0, exmem_zero}, 32'd1);

      alu_op(4'b0101, 32'hFFFF_FFFF, 32'd1, 5'd5); step();
      check("slt neg", exmem_result, 32'd1);

      alu_op(4'b0101, 32'd0, 32'd9, 5'd5); alu_src = 1; imm = 32'hFFFF_FFFE; step();
      check("slt imm", exmem_result, 32'd0);

      alu_op(4'b0000, 32'h10, 32'd0, 5'd6); step();
      alu_op(4'b0000, 32'hDEAD, 32'd3, 5'd7); fwd_a = 2'b10; step();
      check("fwd exmem", exmem_result, 32'h13);

      alu_op(4'b0000, 32'h100, 32'h55, 5'd0); reg_write_in = 0; mem_write_in = 1;
      alu_src = 1; imm = 32'd8; fwd_b = 2'b01; wb_data = 32'd7; step();
      check("sw store", exmem_store_data, 32'd7);
      check("sw addr",  exmem_result, 32'h108);
      check("sw memwrite", {31'd0, exmem_mem_write}, 32'd1);

      alu_op(4'b0011, 32'hF0, 32'h0F, 5'd9); step();
      check("or", exmem_result, 32'hFF);
      alu_op(4'b0010, 32'hF0, 32'h3C, 5'd10); mem_stall = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall hold", exmem_result, 32'hFF);
         check("stall rd",   {27'd0, exmem_rd}, 32'd9);
      end
      mem_stall = 0; step();
      check("and", exmem_result, 32'h30);

      alu_op(4'b0000, 32'd1, 32'd2, 5'd11); mem_write_in = 1; flush = 1; mem_stall = 1; step();
      check("flush valid", {31'd0, exmem_valid}, 32'd0);
      check("flush ctrl",  {28'd0, exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg}, 32'd0);

      alu_op(4'b0000, 32'd1, 32'd2, 5'd12); in_valid = 0; mem_write_in = 1; mem_to_reg_in = 1; step();
      check("bubble ctrl", {28'd0, exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_mem_to_reg}, 32'd0);

      alu_op(4'b1111, 32'd5, 32'd6, 5'd13); step();
      check("undef code", exmem_result, 32'd0);

      // Multiply: 0x00010003 * 5
      alu_op(4'b0110, 32'h0001_0003, 32'd5, 5'd14);
      #1;
      if (MULT_EN) begin
         check("mul busy start", {31'd0, ex_busy}, 32'd1);
         busy_cycles = 1;
         for (int k = 0; k < 40; k++) begin
            step();
            if (!ex_busy) break;
            busy_cycles++;
         end
         check("mul busy cycles", busy_cycles, 32);
         step();
         check("mul result", exmem_result, 32'h0005_000F);
         check("mul valid",  {31'd0, exmem_valid}, 32'd1);

         // Flush while the counter is at 10
         alu_op(4'b0110, 32'd3, 32'd4, 5'd15);
         for (int k = 0; k < 11; k++) step();
         check("mul mid busy", {31'd0, ex_busy}, 32'd1);
         flush = 1; step();
         idle(); #1;
         check("mul flush busy",  {31'd0, ex_busy}, 32'd0);
         check("mul flush valid", {31'd0, exmem_valid}, 32'd0);
      end else begin
         check("nomul busy", {31'd0, ex_busy}, 32'd0);
         step();
         check("nomul result", exmem_result, 32'd0);
         check("nomul valid",  {31'd0, exmem_valid}, 32'd1);
         idle();
      end

      step(); step();
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
